// File: rtl/bridge_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_arbiter
//
// Shares the single system-bridge port between two bus masters (master 0 is
// the CPU data port, master 1 a secondary master such as DMA or a boot
// loader). Simultaneous requests are resolved round-robin against the last
// granted master. Each granted access is decoded into the bridge's one-hot
// hit vector, stretched by per-device wait states, and completed with a
// single-cycle acknowledge carrying read data and an unmapped-address error.
//
// Parameters
//   WAIT_SLOW  wait cycles inserted for Dev2..Dev5 (0..15)
//   MEM_TOP    memory occupies addresses below this value
//   DEV_BASE   base of the device window; Dev n at DEV_BASE + n*16'h10
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   mX_req/we/addr/be/wd       master X request; held stable until ack
//   mX_ack/err/rd              one-cycle completion pulse, error, read data
//   PrAddr/PrBE/PrWD/PrWE      bridge address, byte enables, data, write strobe
//   PrHIT                      one-hot {Dev5..Dev0, MEM}, high only in ACCESS
//   PrRD                       read data from the bridge
//   busy                       high whenever the sequencer is not idle
//   owner                      index of the current or last granted master
// -----------------------------------------------------------------------------
module bridge_arbiter #(
  parameter int unsigned WAIT_SLOW = 2,
  parameter logic [15:0] MEM_TOP   = 16'h3000,
  parameter logic [15:0] DEV_BASE  = 16'h7F00
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wd,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rd,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wd,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rd,

  output logic [15:0] PrAddr,
  output logic [3:0]  PrBE,
  output logic [31:0] PrWD,
  output logic        PrWE,
  output logic [6:0]  PrHIT,
  input  logic [31:0] PrRD,

  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Device window spans six 16-byte slots.
  localparam logic [15:0] DEV_SPAN = 16'h0060;
  localparam logic [3:0]  SLOW_WAITS = 4'(WAIT_SLOW);

  // ---------------------------------------------------------------------------
  // Address decode: memory takes priority, then the device window; anything
  // else yields an all-zero hit vector, which is what marks it unmapped.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode_hit(input logic [15:0] addr);
    logic [6:0] hit;
    hit = 7'b0;
    if (addr < MEM_TOP) begin
      hit = 7'b0000001;
    end else if ((addr >= DEV_BASE) && ((addr - DEV_BASE) < DEV_SPAN)) begin
      // Slot index (addr - DEV_BASE) >> 4 is 0..5 here; Dev n sits at bit n+1.
      hit = 7'b0000010 << ((addr - DEV_BASE) >> 4);
    end
    return hit;
  endfunction

  // Dev2..Dev5 are the slow peripherals; memory, Dev0/Dev1 and unmapped
  // accesses complete without added waits.
  function automatic logic [3:0] waits_for(input logic [6:0] hit);
    return (|hit[6:3]) ? SLOW_WAITS : 4'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] addr_q,  addr_d;
  logic [3:0]  be_q,    be_d;
  logic [31:0] wd_q,    wd_d;
  logic        we_q,    we_d;
  logic [3:0]  wait_q,  wait_d;
  logic [31:0] rd_q,    rd_d;
  logic        err_q,   err_d;

  // ---------------------------------------------------------------------------
  // Grant selection and request mux (only consulted in IDLE)
  // ---------------------------------------------------------------------------
  logic        any_req;
  logic        gnt_m1;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wd;

  assign any_req = m0_req | m1_req;

  // On a tie the master that did not own the bridge last wins; otherwise the
  // lone requester wins. owner resets to 1 so master 0 takes the first tie.
  assign gnt_m1 = (m0_req && m1_req) ? ~owner_q : m1_req;

  assign sel_we   = gnt_m1 ? m1_we   : m0_we;
  assign sel_addr = gnt_m1 ? m1_addr : m0_addr;
  assign sel_be   = gnt_m1 ? m1_be   : m0_be;
  assign sel_wd   = gnt_m1 ? m1_wd   : m0_wd;

  // ---------------------------------------------------------------------------
  // Decode of the latched access, used throughout ACCESS
  // ---------------------------------------------------------------------------
  logic [6:0] hit_dec;
  logic       mapped;
  logic       in_access;
  logic       in_resp;
  logic       last_cycle;

  assign hit_dec    = decode_hit(addr_q);
  assign mapped     = |hit_dec;
  assign in_access  = (state_q == ST_ACCESS);
  assign in_resp    = (state_q == ST_RESP);
  assign last_cycle = in_access && (wait_q == 4'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; a missing default in always_comb infers a latch.
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    we_d    = we_q;
    wait_d  = wait_q;
    rd_d    = rd_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = gnt_m1;
          addr_d  = sel_addr;
          be_d    = sel_be;
          wd_d    = sel_wd;
          we_d    = sel_we;
          wait_d  = waits_for(decode_hit(sel_addr));
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (wait_q != 4'd0) begin
          // Counts down to zero only; it is reloaded in IDLE, never wrapped.
          wait_d = wait_q - 4'd1;
        end else begin
          rd_d    = mapped ? PrRD : 32'h0;
          err_d   = ~mapped;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the latched bridge fields and response data are reset as well, so
  // PrAddr/PrBE/PrWD and rd come out of reset at zero rather than X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b1;
      addr_q  <= 16'h0;
      be_q    <= 4'h0;
      wd_q    <= 32'h0;
      we_q    <= 1'b0;
      wait_q  <= 4'd0;
      rd_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Bridge strobes are decoded from the state register, so an asynchronous
  // reset drops them immediately.
  assign PrAddr = addr_q;
  assign PrBE   = be_q;
  assign PrWD   = wd_q;
  assign PrHIT  = in_access ? hit_dec : 7'b0;
  // Write strobe only in the final ACCESS cycle: each write is issued once.
  assign PrWE   = last_cycle & we_q & mapped;

  assign m0_ack = in_resp & ~owner_q;
  assign m1_ack = in_resp &  owner_q;
  assign m0_err = m0_ack & err_q;
  assign m1_err = m1_ack & err_q;
  assign m0_rd  = m0_ack ? rd_q : 32'h0;
  assign m1_rd  = m1_ack ? rd_q : 32'h0;

  assign busy   = (state_q != ST_IDLE);
  assign owner  = owner_q;

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Two-master arbiter and access sequencer in front of the system bridge. It shares the single bridge port between the CPU data port (master 0) and a secondary bus master such as the DMA or boot loader (master 1), with round-robin priority. For each access it decodes the address into the bridge's 7-bit one-hot hit vector and inserts per-device wait states. It then returns read data with a one-cycle acknowledge to the granted master.

## Interface
- `WAIT_SLOW`, default 2: wait cycles added for Dev2..Dev5 (0..15).
- `MEM_TOP`, default 16'h3000: memory occupies addresses below this value.
- `DEV_BASE`, default 16'h7F00: base of the device window; Dev n occupies DEV_BASE + n*16'h10 .. +16'h0F, n = 0..5.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held high, with the other master inputs stable, until ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  16  byte address.
- `m0_be`, `m1_be`  in  4  byte enables.
- `m0_wd`, `m1_wd`  in  32  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  valid with ack; 1 = unmapped address.
- `m0_rd`, `m1_rd`  out  32  read data, valid while ack is high.
- `PrAddr`  out  16  address to bridge.
- `PrBE`  out  4  byte enables to bridge.
- `PrWD`  out  32  write data to bridge.
- `PrWE`  out  1  write strobe to bridge.
- `PrHIT`  out  7  one-hot hit vector to bridge: {Dev5..Dev0, MEM}.
- `PrRD`  in  32  read data from bridge.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  index of the current or last granted master.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE
  - Requests are sampled at the clock edge.
  - Only one req high: grant that master.
  - Both high: grant the master that is not `owner` (round-robin).
  - Latch the granted master's addr/we/be/wd into PrAddr/PrWE-pending/PrBE/PrWD registers.
  - Load the wait counter, set `owner`, go to ACCESS.
  - No req: stay in IDLE.
- Decode (from the latched address)
  - addr < MEM_TOP: MEM.
  - DEV_BASE <= addr < DEV_BASE + 16'h60: Dev (addr - DEV_BASE) >> 4.
  - Anything else is unmapped: PrHIT = 0 and err = 1.
  - MEM, Dev0 and Dev1 get 0 wait cycles; Dev2..Dev5 get WAIT_SLOW; unmapped gets 0.
- ACCESS
  - PrHIT is driven for every ACCESS cycle.
  - Wait counter > 0: decrement and stay.
  - Wait counter = 0 (final cycle):
    - PrWE = latched we AND mapped; this is the only cycle PrWE can be high, so a write is issued exactly once.
    - Capture rd = mapped ? PrRD : 0.
    - Capture err.
    - Go to RESP.
- RESP
  - Granted master's ack = 1, with rd/err valid.
  - The other master's ack stays 0.
  - Go to IDLE.
- Outside ACCESS, PrHIT = 0 and PrWE = 0. PrAddr, PrBE and PrWD hold their last latched values.
- Master rule: lower req in the cycle after ack. A req still high in IDLE starts a new transaction.
- Requests arriving during ACCESS or RESP wait; they are not lost while held.

## Timing
- Reset values (asynchronous, while reset_n = 0):
  - State = IDLE.
  - `owner` = 1, so master 0 wins the first tie.
  - All acks, errs, rd, PrAddr, PrBE, PrWD, PrWE, PrHIT and busy = 0.
  - The wait counter also resets.
- Reset mid-transaction: the access is aborted with no ack, and PrWE/PrHIT drop immediately. After release the block is in IDLE.
- Latency, counted from the edge at which req is sampled in IDLE (cycle 0):
  - ACCESS occupies cycles 1 .. 1 + waits.
  - Ack is in cycle 2 + waits.
  - A fast device acks in cycle 2; Dev2..Dev5 with WAIT_SLOW = 2 ack in cycle 4.
- Throughput: one transaction per 3 + waits cycles. Two masters continuously requesting alternate grants.
- Wait counter: 4 bits, no wrap; it counts down to 0 only.

## Test plan
- Master 0 reads 16'h0010 with PrRD = 32'hDEADBEEF: PrHIT = 7'b0000001 in cycle 1 only; m0_ack in cycle 2 with m0_rd = 32'hDEADBEEF and m0_err = 0; m1_ack = 0 throughout.
- Master 1 writes 32'h12345678, be = 4'hF, to 16'h7F24 (Dev2) with WAIT_SLOW = 2: PrHIT = 7'b0001000 for cycles 1–3; PrWE high only in cycle 3; m1_ack in cycle 4.
- Both masters request from reset and keep re-requesting: grants are m0, m1, m0, m1; ack spacing is 3 cycles for MEM addresses.
- m0 accesses unmapped address 16'h5000: PrHIT = 0 and PrWE = 0 throughout; ack in cycle 2 with m0_err = 1 and m0_rd = 0.
- Write to Dev1 (16'h7F10), with reset_n pulsed low during ACCESS: PrWE and PrHIT go to 0 at once; no ack; busy = 0 and owner = 1 after release; a following m0 request completes normally.
